register_file: RTL and testbench



---
 rtl/register_file.sv | 46 ++++
 tb/tb_register_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Optional write-through forwarding from the write port to the read ports: define REGFILE_BYPASS_EN.
module register_file #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic [AddrWidth-1:0] ReadRegister1,
  input  logic [AddrWidth-1:0] ReadRegister2,
  input  logic [DataWidth-1:0] WriteData,
  input  logic [AddrWidth-1:0] WriteReg,
  input  logic                 RegWriteActive,
  output logic [DataWidth-1:0] ReadData1,
  output logic [DataWidth-1:0] ReadData2
);

  localparam int Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] regs [Depth];
  logic                 writeEn;

  // An X/Z enable compares unequal to 1 and therefore never writes.
  assign writeEn = (RegWriteActive == 1'b1) && (WriteReg != '0);

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      regs <= '{default: '0};
    end else if (writeEn) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // r0 is decoded on the address so it reads zero even before the first reset.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != '0) ReadData1 = regs[ReadRegister1];
    if (ReadRegister2 != '0) ReadData2 = regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if (ResetN && writeEn && (WriteReg == ReadRegister1)) ReadData1 = WriteData;
    if (ResetN && writeEn && (WriteReg == ReadRegister2)) ReadData2 = WriteData;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written corner sequences,
// then randomized traffic against an array-based reference model.
module tb_register_file;

  logic        Clk;
  logic        ResetN;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] WriteData;
  logic [4:0]  WriteReg;
  logic        RegWriteActive;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        rstN;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [10];

  register_file dut (
    .Clk(Clk),
    .ResetN(ResetN),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteData(WriteData),
    .WriteReg(WriteReg),
    .RegWriteActive(RegWriteActive),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Reference: architectural register contents updated by the write rules.
  task automatic tick();
    if (ResetN === 1'b0) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWriteActive === 1'b1 && WriteReg != 5'd0) begin
      model[WriteReg] = WriteData;
    end
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (ResetN === 1'b1 && RegWriteActive === 1'b1 && WriteReg != 5'd0 && WriteReg == addr)
      return WriteData;
`endif
    return model[addr];
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5'd0,  32'h0000_0000, 5'd4,  5'd7,  32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 5'd0,  32'h0000_0112, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  32'h0000_0112, 5'd0,  5'd31, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 5'd16, 32'h8000_0000, 5'd16, 5'd4,  32'h8000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b0, 5'd7,  32'hFFFF_FFFF, 5'd7,  5'd16, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{1'b0, 1'b1, 5'd9,  32'h1234_5678, 5'd9,  5'd16, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b1, 5'd9,  32'h1234_5678, 5'd9,  5'd9,  32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd9,  32'hFFFF_FFFF, 32'h1234_5678};
    vecs[8] = '{1'b1, 1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[9] = '{1'b1, 1'b1, 5'd31, 32'h0000_0000, 5'd31, 5'd1,  32'h0000_0000, 32'h0000_0001};

    ResetN = 1'b1;
    RegWriteActive = 1'b0;
    WriteReg = 5'd0;
    WriteData = 32'h0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    #1;
    check("r0_before_reset_p1", ReadData1, 32'h0);
    check("r0_before_reset_p2", ReadData2, 32'h0);

    ResetN = 1'b0;
    tick();
    tick();

    // Directed table: apply write-side inputs for one edge, then read back with writes off.
    for (int v = 0; v < 10; v++) begin
      ResetN = vecs[v].rstN;
      RegWriteActive = vecs[v].we;
      WriteReg = vecs[v].wr;
      WriteData = vecs[v].wd;
      tick();
      ResetN = 1'b1;
      RegWriteActive = 1'b0;
      ReadRegister1 = vecs[v].ra1;
      ReadRegister2 = vecs[v].ra2;
      #1;
      check($sformatf("vec%0d_rd1", v), ReadData1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), ReadData2, vecs[v].exp2);
    end

    // Unknown write enable must not write.
    RegWriteActive = 1'bx;
    WriteReg = 5'd5;
    WriteData = 32'hDEAD_BEEF;
    tick();
    RegWriteActive = 1'b0;
    ReadRegister1 = 5'd5;
    #1;
    check("x_enable_r5", ReadData1, 32'h0);

    // Same-cycle read/write of r3 (r3 cleared by the reset in the table).
    RegWriteActive = 1'b1;
    WriteReg = 5'd3;
    WriteData = 32'hA5A5_A5A5;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rdw_r3_before_edge", ReadData1, 32'hA5A5_A5A5);
`else
    check("rdw_r3_before_edge", ReadData1, 32'h0);
`endif
    check("rdw_r0_before_edge", ReadData2, 32'h0);
    tick();
    RegWriteActive = 1'b0;
    ReadRegister2 = 5'd3;
    #1;
    check("rdw_r3_after_edge_p1", ReadData1, 32'hA5A5_A5A5);
    check("rdw_r3_after_edge_p2", ReadData2, 32'hA5A5_A5A5);

    // Reset mid-operation clears everything regardless of addresses.
    ResetN = 1'b0;
    RegWriteActive = 1'b1;
    WriteReg = 5'd3;
    WriteData = 32'h5555_5555;
    tick();
    ResetN = 1'b1;
    RegWriteActive = 1'b0;
    #1;
    check("reset_mid_r3_p1", ReadData1, 32'h0);
    check("reset_mid_r3_p2", ReadData2, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      ResetN = ($urandom_range(0, 29) != 0);
      RegWriteActive = $urandom_range(0, 1);
      WriteReg = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rand%0d_rd1", n), ReadData1, expRead(ReadRegister1));
      check($sformatf("rand%0d_rd2", n), ReadData2, expRead(ReadRegister2));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
